// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Imported by the fetch FSM and the instruction cache.
package if_stage_pkg;

  localparam logic [31:0] Zero = 32'h0;
  localparam int InstLen = 32;

  localparam int StallPc   = 0;
  localparam int StallIfId = 1;

  typedef enum logic {
    Idle = 1'b0,
    Fill = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped, one-word-per-line instruction cache.
// Combinational lookup, one synchronous write port, valid bits cleared on rst.
import if_stage_pkg::*;

module if_stage_icache #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  output logic [InstLen-1:0] rd_data,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [InstLen-1:0] wr_data
);

  localparam int Lines = 1 << IDX_W;

  logic [Lines-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [Lines];
  logic [InstLen-1:0] data_q [Lines];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: icache lookup, byte-serial refill on miss,
// and the registered IF/ID outputs.
import if_stage_pkg::*;

module if_stage #(
  parameter int IDX_W  = 7,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               jump_flag,
  input  logic [4:0]         stall_signal,
  output logic               stallreq_if,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rdy,
  input  logic [7:0]         mem_data,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [InstLen-1:0] if_inst,
  output logic               if_valid
);

  localparam int TagW = ADDR_W - IDX_W - 2;

  if_state_e          state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
  logic [TagW-1:0]    fill_tag_q, fill_tag_d;
  logic [23:0]        asm_q, asm_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [InstLen-1:0] if_inst_q, if_inst_d;
  logic               if_valid_q, if_valid_d;

  logic               hit;
  logic [InstLen-1:0] rd_data;
  logic               cache_we;
  logic [IDX_W-1:0]   pc_idx;
  logic [TagW-1:0]    pc_tag;
  logic               unused_ok;

  assign pc_idx    = pc[IDX_W+1:2];
  assign pc_tag    = pc[ADDR_W-1:IDX_W+2];
  assign unused_ok = ^{pc[1:0], stall_signal[4:2], stall_signal[StallPc]};

  if_stage_icache #(
    .IDX_W (IDX_W),
    .TAG_W (TagW)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc_idx),
    .rd_tag  (pc_tag),
    .hit     (hit),
    .rd_data (rd_data),
    .we      (cache_we),
    .wr_idx  (fill_idx_q),
    .wr_tag  (fill_tag_q),
    .wr_data ({mem_data, asm_q})
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    fill_idx_d = fill_idx_q;
    fill_tag_d = fill_tag_q;
    asm_d      = asm_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cache_we   = 1'b0;

    if (jump_flag) begin
      state_d   = Idle;
      mem_req_d = 1'b0;
      beat_d    = '0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (!hit) begin
            state_d    = Fill;
            fill_idx_d = pc_idx;
            fill_tag_d = pc_tag;
            mem_addr_d = pc;
            mem_req_d  = 1'b1;
            beat_d     = '0;
          end
        end
        Fill: begin
          if (mem_rdy) begin
            beat_d     = beat_q + 2'd1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            unique case (beat_q)
              2'd0: asm_d[7:0]   = mem_data;
              2'd1: asm_d[15:8]  = mem_data;
              2'd2: asm_d[23:16] = mem_data;
              default: begin
                // last byte goes straight into the cache word
                cache_we  = 1'b1;
                mem_req_d = 1'b0;
                state_d   = Idle;
              end
            endcase
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_comb begin
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    if (jump_flag) begin
      if_pc_d    = '0;
      if_inst_d  = Zero;
      if_valid_d = 1'b0;
    end else if (stall_signal[StallIfId]) begin
      if_valid_d = if_valid_q;
    end else if (hit && state_q == Idle) begin
      if_pc_d    = pc;
      if_inst_d  = rd_data;
      if_valid_d = 1'b1;
    end else begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= Idle;
      beat_q     <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      asm_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= Zero;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      asm_q      <= asm_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign stallreq_if = !jump_flag && (state_q == Fill || !hit);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign if_valid    = if_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: refill, hit, aliasing, jump flush,
// IF/ID hold and mid-refill reset.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        jump_flag;
  logic [4:0]  stall_signal;
  logic        stallreq_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [7:0]  mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int checks;
  int failures;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .jump_flag    (jump_flag),
    .stall_signal (stall_signal),
    .stallreq_if  (stallreq_if),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdy      (mem_rdy),
    .mem_data     (mem_data),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss at address a, serve word w byte by byte, check delivery.
  task automatic fetch_miss(input logic [31:0] a, input logic [31:0] w);
    pc = a;
    #1;
    chk("miss_stallreq", 32'(stallreq_if), 32'd1);
    step();
    chk("fill_mem_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("beat_addr", mem_addr, a + 32'(i));
      chk("beat_stall", 32'(stallreq_if), 32'd1);
      mem_rdy  = 1'b1;
      mem_data = w[8*i +: 8];
      step();
      mem_rdy  = 1'b0;
    end
    chk("post_fill_stall", 32'(stallreq_if), 32'd0);
    chk("post_fill_req", 32'(mem_req), 32'd0);
    chk("post_fill_valid", 32'(if_valid), 32'd0);
    step();
    chk("deliver_inst", if_inst, w);
    chk("deliver_pc", if_pc, a);
    chk("deliver_valid", 32'(if_valid), 32'd1);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    pc           = 32'h0;
    jump_flag    = 1'b0;
    stall_signal = 5'd0;
    mem_rdy      = 1'b0;
    mem_data     = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    fetch_miss(32'h0, 32'h0010_0513);

    step();
    chk("hit_stall", 32'(stallreq_if), 32'd0);
    chk("hit_req", 32'(mem_req), 32'd0);
    chk("hit_inst", if_inst, 32'h0010_0513);
    chk("hit_valid", 32'(if_valid), 32'd1);

    mem_rdy  = 1'b1;
    mem_data = 8'hff;
    step();
    mem_rdy = 1'b0;
    chk("idle_rdy_req", 32'(mem_req), 32'd0);
    chk("idle_rdy_inst", if_inst, 32'h0010_0513);

    fetch_miss(32'h200, 32'hdead_beef);
    pc = 32'h0;
    #1;
    chk("alias_miss", 32'(stallreq_if), 32'd1);
    fetch_miss(32'h0, 32'h0010_0513);

    fetch_miss(32'h4, 32'h00a0_0593);
    pc = 32'h0;
    step();
    chk("pre_hold_pc", if_pc, 32'h0);
    pc = 32'h4;
    stall_signal = 5'b00010;
    step();
    step();
    chk("hold_pc", if_pc, 32'h0);
    chk("hold_inst", if_inst, 32'h0010_0513);
    chk("hold_valid", 32'(if_valid), 32'd1);
    stall_signal = 5'd0;
    step();
    chk("release_pc", if_pc, 32'h4);
    chk("release_inst", if_inst, 32'h00a0_0593);

    pc = 32'h8;
    step();
    chk("bubble_valid", 32'(if_valid), 32'd0);
    chk("bubble_pc", if_pc, 32'h4);
    for (int i = 0; i < 2; i++) begin
      mem_rdy  = 1'b1;
      mem_data = 8'h5a;
      step();
      mem_rdy = 1'b0;
    end
    jump_flag    = 1'b1;
    stall_signal = 5'b00010;
    #1;
    chk("jump_stall_forced", 32'(stallreq_if), 32'd0);
    step();
    jump_flag    = 1'b0;
    stall_signal = 5'd0;
    chk("jump_req", 32'(mem_req), 32'd0);
    chk("jump_valid", 32'(if_valid), 32'd0);
    chk("jump_pc", if_pc, 32'h0);
    chk("jump_inst", if_inst, 32'h0);
    fetch_miss(32'h8, 32'h1234_5678);

    pc = 32'h10;
    step();
    mem_rdy  = 1'b1;
    mem_data = 8'h77;
    step();
    mem_rdy = 1'b0;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_pc", if_pc, 32'h0);
    chk("mid_rst_inst", if_inst, 32'h0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    fetch_miss(32'h0, 32'h0010_0513);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Consumes the current pc and looks it up in a direct-mapped, word-granular instruction cache.
- On a miss, refills the word from the byte-serial memory controller (4 little-endian byte beats) and requests a pipeline stall until the word is available.
- Produces the registered IF/ID outputs (if_pc, if_inst, if_valid) consumed by the decode stage.

Parameters:
- IDX_W, 7, index width; cache holds 2^IDX_W one-word lines (128 lines, 512 B).
- ADDR_W, 32, instruction address width; tag = ADDR_W-IDX_W-2 bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch address from the PC register; word aligned.
- jump_flag  in  1  branch/jump redirect; flushes fetch.
- stall_signal  in  5  stall vector; bit0 = PC hold, bit1 = IF/ID hold.
- stallreq_if  out  1  stall request to the stall controller; high while the current pc misses.
- mem_req  out  1  byte read request to the memory controller.
- mem_addr  out  32  byte address of the current beat.
- mem_rdy  in  1  one-cycle pulse; mem_data is valid for mem_addr.
- mem_data  in  8  returned byte.
- if_pc  out  32  registered pc of the delivered instruction.
- if_inst  out  32  registered instruction word.
- if_valid  out  1  if_inst is meaningful.

Behaviour:
Address split:
- index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
- hit = valid[index] && tag_ram[index]==tag (combinational).

Reset (rst at a clock edge):
- Clears all valid bits.
- Sets if_pc=0, if_inst=0, if_valid=0, state=IDLE, beat counter=0, mem_req=0, mem_addr=0.
- Aborts any refill in progress; bytes already collected are discarded.

FSM states: IDLE, FILL.
- IDLE, hit: no memory activity; stallreq_if=0.
- IDLE, miss, no jump_flag: next state FILL; latch fill_pc=pc; mem_addr<=pc; mem_req<=1; beat<=0.
- FILL: mem_req stays high. On each mem_rdy:
  - Write mem_data into byte lane beat of the assembly register (beat 0 -> bits 7:0, little-endian).
  - beat<=beat+1; mem_addr<=mem_addr+1.
- FILL, 4th mem_rdy (beat==3): write the word, tag, and valid=1 into line index(fill_pc); mem_req<=0; next state IDLE.
  - The following cycle hits, so miss latency = 4 beats + 1 cycle.
- mem_rdy while IDLE: ignored.

stallreq_if:
- Combinational: (state==FILL) || (state==IDLE && !hit).
- Forced 0 while jump_flag is high.

IF/ID output register, updated at each edge:
- jump_flag: if_valid<=0, if_inst<=0, if_pc<=0. FILL aborts to IDLE, mem_req<=0, cache line not written, and a coincident mem_rdy is ignored. jump_flag takes priority over stall_signal and over a completing beat.
- else stall_signal[1]: hold all three outputs.
- else hit and state==IDLE: if_pc<=pc, if_inst<=cached word, if_valid<=1.
- else (miss or FILL): if_valid<=0 (bubble); if_pc and if_inst hold.

Other rules:
- Refill proceeds regardless of stall_signal.
- stallreq_if keeps the PC register holding pc stable for the whole miss.
- Misaligned pc (pc[1:0]!=0) is not supported; the low bits are ignored for indexing.
- Cache write and output-register update never occur in the same cycle for the same line.
- Beat counter is 2 bits; after the 4th beat it wraps to 0.

Decomposition:
- Shared defines file: Zero (32'h0), InstLen (32), stall-vector bit positions (StallPc=0, StallIfId=1), FSM state encodings.
- Sub-module icache: valid/tag/data arrays, combinational hit/read port, single synchronous write port, synchronous valid clear on rst.
- if_stage holds the FSM, byte assembly, and the IF/ID output register.

Test Plan:
- Reset, then pc=0x0 with bytes 13,05,10,00 (one per mem_rdy) -> mem_addr 0x0..0x3, stallreq_if high 4 beats, then if_inst=0x00100513, if_pc=0, if_valid=1.
- Re-fetch pc=0x0 -> hit: stallreq_if=0, no mem_req, if_inst=0x00100513 next edge.
- Aliasing: pc=0x200 (same index as 0x0, different tag) -> miss and refill; a later pc=0x0 misses again.
- jump_flag pulsed after 2 of 4 beats -> mem_req drops next cycle, if_valid=0; the old line stays invalid and re-fetching that pc misses.
- stall_signal[1]=1 while hit at pc=0x4 -> if_pc/if_inst/if_valid unchanged; after release, if_pc=0x4 next edge.
- rst asserted mid-FILL -> all outputs 0 and state IDLE next edge; a previously cached pc now misses.
